// File: rtl/wb_retire_queue_pkg.sv
// rtl/wb_retire_queue_pkg.sv - shared widths and entry layout for the writeback retire queue
package wb_retire_queue_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;
  localparam int WB_PC_W   = 32;

  // Entry layout, MSB first: pc, rf_we, rf_waddr, rf_wdata, hi_we, lo_we, hi, lo
  function automatic int wb_ent_wd(input int pc_w, input int addr_w, input int data_w);
    return pc_w + 3 + addr_w + 3 * data_w;
  endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// rtl/wb_fwd_match.sv - youngest-first priority matcher over age-ordered queue entries
module wb_fwd_match #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic [DEPTH-1:0]             match,
  input  logic [DEPTH-1:0][DATA_W-1:0] data,
  output logic                         hit,
  output logic [DATA_W-1:0]            sel_data
);

  // Index 0 is the oldest entry; later indices overwrite so the youngest match wins.
  always_comb begin
    hit      = 1'b0;
    sel_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match[i]) begin
        hit      = 1'b1;
        sel_data = data[i];
      end
    end
  end

endmodule

// File: rtl/wb_retire_queue.sv
// rtl/wb_retire_queue.sv - DEPTH-entry writeback queue with in-order retire and ID forwarding
module wb_retire_queue
  import wb_retire_queue_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int PC_W   = WB_PC_W,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc,
  input  logic                       in_rf_we,
  input  logic [ADDR_W-1:0]          in_rf_waddr,
  input  logic [DATA_W-1:0]          in_rf_wdata,
  input  logic                       in_hi_we,
  input  logic                       in_lo_we,
  input  logic [DATA_W-1:0]          in_hi,
  input  logic [DATA_W-1:0]          in_lo,
  input  logic                       retire_hold,
  output logic                       rf_we,
  output logic [ADDR_W-1:0]          rf_waddr,
  output logic [DATA_W-1:0]          rf_wdata,
  output logic                       hi_we,
  output logic                       lo_we,
  output logic [DATA_W-1:0]          hi_o,
  output logic [DATA_W-1:0]          lo_o,
  input  logic [ADDR_W-1:0]          id_raddr1,
  input  logic [ADDR_W-1:0]          id_raddr2,
  output logic                       fwd_hit1,
  output logic [DATA_W-1:0]          fwd_data1,
  output logic                       fwd_hit2,
  output logic [DATA_W-1:0]          fwd_data2,
  output logic                       fwd_hi_hit,
  output logic [DATA_W-1:0]          fwd_hi,
  output logic                       fwd_lo_hit,
  output logic [DATA_W-1:0]          fwd_lo,
  output logic [$clog2(DEPTH):0]     count,
  output logic [PC_W-1:0]            debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [ADDR_W-1:0]          debug_wb_rf_wnum,
  output logic [DATA_W-1:0]          debug_wb_rf_wdata
);

  localparam int IW        = $clog2(DEPTH);
  localparam int PW        = IW + 1;
  localparam int ENT_W     = wb_ent_wd(PC_W, ADDR_W, DATA_W);
  localparam int LO_LSB    = 0;
  localparam int HI_LSB    = DATA_W;
  localparam int LO_WE     = 2 * DATA_W;
  localparam int HI_WE     = 2 * DATA_W + 1;
  localparam int WDATA_LSB = 2 * DATA_W + 2;
  localparam int WADDR_LSB = 3 * DATA_W + 2;
  localparam int RF_WE     = WADDR_LSB + ADDR_W;
  localparam int PC_LSB    = RF_WE + 1;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             full, empty, accept, fire;
  logic [ENT_W-1:0] head;

  assign full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign count    = wr_ptr - rd_ptr;
  assign in_ready = !rst && !full;
  assign accept   = in_valid && in_ready;
  assign fire     = !empty && !retire_hold;
  assign head     = mem[rd_ptr[IW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr[IW-1:0]] <= {in_pc, in_rf_we, in_rf_waddr, in_rf_wdata,
                                in_hi_we, in_lo_we, in_hi, in_lo};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fire) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rf_we    = fire && head[RF_WE];
  assign hi_we    = fire && head[HI_WE];
  assign lo_we    = fire && head[LO_WE];
  assign rf_waddr = fire ? head[WADDR_LSB +: ADDR_W] : '0;
  assign rf_wdata = fire ? head[WDATA_LSB +: DATA_W] : '0;
  assign hi_o     = fire ? head[HI_LSB +: DATA_W] : '0;
  assign lo_o     = fire ? head[LO_LSB +: DATA_W] : '0;

  assign debug_wb_pc       = fire ? head[PC_LSB +: PC_W] : '0;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  // Re-index storage by age (0 = head) so the matchers only need positional priority.
  logic [DEPTH-1:0]             m1, m2, mhi, mlo;
  logic [DEPTH-1:0][DATA_W-1:0] d_rf, d_hi, d_lo;
  logic [ENT_W-1:0]             ent;
  logic                         ent_valid;

  always_comb begin
    m1 = '0; m2 = '0; mhi = '0; mlo = '0;
    d_rf = '0; d_hi = '0; d_lo = '0;
    ent = '0;
    ent_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ent       = mem[IW'(rd_ptr[IW-1:0] + IW'(i))];
      ent_valid = (PW'(i) < count);
      m1[i]   = ent_valid && ent[RF_WE] && (id_raddr1 != '0) &&
                (ent[WADDR_LSB +: ADDR_W] == id_raddr1);
      m2[i]   = ent_valid && ent[RF_WE] && (id_raddr2 != '0) &&
                (ent[WADDR_LSB +: ADDR_W] == id_raddr2);
      mhi[i]  = ent_valid && ent[HI_WE];
      mlo[i]  = ent_valid && ent[LO_WE];
      d_rf[i] = ent[WDATA_LSB +: DATA_W];
      d_hi[i] = ent[HI_LSB +: DATA_W];
      d_lo[i] = ent[LO_LSB +: DATA_W];
    end
  end

  wb_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fwd1 (
    .match(m1), .data(d_rf), .hit(fwd_hit1), .sel_data(fwd_data1));
  wb_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fwd2 (
    .match(m2), .data(d_rf), .hit(fwd_hit2), .sel_data(fwd_data2));
  wb_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fwd_hi (
    .match(mhi), .data(d_hi), .hit(fwd_hi_hit), .sel_data(fwd_hi));
  wb_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fwd_lo (
    .match(mlo), .data(d_lo), .hit(fwd_lo_hit), .sel_data(fwd_lo));

endmodule

// File: tb/tb_wb_retire_queue.sv
// tb/tb_wb_retire_queue.sv - scoreboard bench for wb_retire_queue against a queue reference model
module tb_wb_retire_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic        in_rf_we = 1'b0;
  logic [4:0]  in_rf_waddr = '0;
  logic [31:0] in_rf_wdata = '0;
  logic        in_hi_we = 1'b0;
  logic        in_lo_we = 1'b0;
  logic [31:0] in_hi = '0;
  logic [31:0] in_lo = '0;
  logic        retire_hold = 1'b0;
  logic        rf_we, hi_we, lo_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, hi_o, lo_o;
  logic [4:0]  id_raddr1 = '0;
  logic [4:0]  id_raddr2 = '0;
  logic        fwd_hit1, fwd_hit2, fwd_hi_hit, fwd_lo_hit;
  logic [31:0] fwd_data1, fwd_data2, fwd_hi, fwd_lo;
  logic [2:0]  count;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  wb_retire_queue #(.DATA_W(32), .ADDR_W(5), .PC_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
    .in_rf_wdata(in_rf_wdata), .in_hi_we(in_hi_we), .in_lo_we(in_lo_we),
    .in_hi(in_hi), .in_lo(in_lo), .retire_hold(retire_hold),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hi_we(hi_we), .lo_we(lo_we), .hi_o(hi_o), .lo_o(lo_o),
    .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
    .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .fwd_hi_hit(fwd_hi_hit), .fwd_hi(fwd_hi),
    .fwd_lo_hit(fwd_lo_hit), .fwd_lo(fwd_lo), .count(count),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
  } ent_t;

  ent_t pend[$];
  logic acc_flag = 1'b0;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a list of pending results, oldest first.
  initial begin : model
    ent_t e;
    int   n;
    logic f, a;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        pend.delete();
        acc_flag = 1'b0;
      end else begin
        n = pend.size();
        f = (n > 0) && !retire_hold;
        a = in_valid && (n < DEPTH);
        if (f) void'(pend.pop_front());
        if (a) begin
          e.pc = in_pc; e.rf_we = in_rf_we; e.waddr = in_rf_waddr; e.wdata = in_rf_wdata;
          e.hi_we = in_hi_we; e.lo_we = in_lo_we; e.hi = in_hi; e.lo = in_lo;
          pend.push_back(e);
        end
        acc_flag = a;
      end
    end
  end

  // Monitor: compares the retire port and forwarding against the model each cycle.
  initial begin : monitor
    ent_t h;
    logic ef, h1, h2, hh, hl;
    logic [31:0] d1, d2, dh, dl;
    forever begin
      @(negedge clk);
      ef = (pend.size() > 0) && !retire_hold && !rst;
      h = '{default: '0};
      if (ef) h = pend[0];
      h1 = 0; h2 = 0; hh = 0; hl = 0; d1 = 0; d2 = 0; dh = 0; dl = 0;
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (!h1 && pend[i].rf_we && id_raddr1 != 0 && pend[i].waddr == id_raddr1) begin h1 = 1; d1 = pend[i].wdata; end
        if (!h2 && pend[i].rf_we && id_raddr2 != 0 && pend[i].waddr == id_raddr2) begin h2 = 1; d2 = pend[i].wdata; end
        if (!hh && pend[i].hi_we) begin hh = 1; dh = pend[i].hi; end
        if (!hl && pend[i].lo_we) begin hl = 1; dl = pend[i].lo; end
      end
      chk("count", 64'(count), 64'(pend.size()));
      chk("in_ready", 64'(in_ready), 64'(!rst && pend.size() < DEPTH));
      chk("debug_wb_pc", 64'(debug_wb_pc), 64'(h.pc));
      chk("rf_we", 64'(rf_we), 64'(h.rf_we));
      chk("rf_waddr", 64'(rf_waddr), 64'(h.waddr));
      chk("rf_wdata", 64'(rf_wdata), 64'(h.wdata));
      chk("hi_we", 64'(hi_we), 64'(h.hi_we));
      chk("lo_we", 64'(lo_we), 64'(h.lo_we));
      chk("hi_o", 64'(hi_o), 64'(h.hi));
      chk("lo_o", 64'(lo_o), 64'(h.lo));
      chk("dbg_wen", 64'(debug_wb_rf_wen), h.rf_we ? 64'hF : 64'h0);
      chk("dbg_wnum", 64'(debug_wb_rf_wnum), 64'(h.waddr));
      chk("dbg_wdata", 64'(debug_wb_rf_wdata), 64'(h.wdata));
      chk("fwd1", {31'(0), fwd_hit1, fwd_data1}, {31'(0), h1, d1});
      chk("fwd2", {31'(0), fwd_hit2, fwd_data2}, {31'(0), h2, d2});
      chk("fwd_hi", {31'(0), fwd_hi_hit, fwd_hi}, {31'(0), hh, dh});
      chk("fwd_lo", {31'(0), fwd_lo_hit, fwd_lo}, {31'(0), hl, dl});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic hwe, input logic lwe,
                        input logic [31:0] hv, input logic [31:0] lv);
    in_valid = 1'b1; in_pc = pc; in_rf_we = we; in_rf_waddr = wa; in_rf_wdata = wd;
    in_hi_we = hwe; in_lo_we = lwe; in_hi = hv; in_lo = lv;
  endtask

  task automatic push_in(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic hwe, input logic lwe,
                         input logic [31:0] hv, input logic [31:0] lv);
    logic got;
    got = 1'b0;
    set_in(pc, we, wa, wd, hwe, lwe, hv, lv);
    for (int k = 0; k < 50 && !got; k++) begin
      step(1);
      got = acc_flag;
    end
    if (!got) chk("push_timeout", 64'(got), 64'd1);
    in_valid = 1'b0;
  endtask

  initial begin : stim
    step(3);
    rst = 1'b0;
    step(1);
    chk("post_reset_ready", 64'(in_ready), 64'd1);

    push_in(32'hBFC00000, 1, 5'd3, 32'h11, 0, 0, 0, 0);
    step(2);

    retire_hold = 1'b1;
    for (int i = 0; i < 4; i++) push_in(32'h1000 + 32'(i * 4), 1, 5'(i + 1), 32'(i + 100), 0, 0, 0, 0);
    set_in(32'h2000, 1, 5'd9, 32'h99, 0, 0, 0, 0);
    step(2);
    retire_hold = 1'b0;
    for (int k = 0; k < 10 && !acc_flag; k++) step(1);
    in_valid = 1'b0;
    step(6);

    retire_hold = 1'b1;
    id_raddr1 = 5'd5; id_raddr2 = 5'd0;
    push_in(32'h3000, 1, 5'd5, 32'hA, 0, 0, 0, 0);
    push_in(32'h3004, 1, 5'd5, 32'hB, 0, 0, 0, 0);
    push_in(32'h3008, 1, 5'd0, 32'hC, 0, 0, 0, 0);
    step(1);
    retire_hold = 1'b0;
    step(4);

    retire_hold = 1'b1;
    push_in(32'h4000, 0, 5'd0, 0, 1, 0, 32'h1, 0);
    push_in(32'h4004, 0, 5'd0, 0, 0, 1, 0, 32'h2);
    step(1);
    retire_hold = 1'b0;
    step(3);

    for (int i = 0; i < 2 * DEPTH + 3; i++) begin
      set_in(32'h5000 + 32'(i * 4), 1, 5'(i % 8), 32'(i), 0, 0, 0, 0);
      step(1);
    end
    in_valid = 1'b0;
    step(2);

    retire_hold = 1'b1;
    id_raddr1 = 5'd7;
    for (int i = 0; i < 3; i++) push_in(32'h6000 + 32'(i * 4), 1, 5'd7, 32'(i + 7), 1, 1, 1, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_count", 64'(count), 64'd0);
    chk("async_ready", 64'(in_ready), 64'd0);
    chk("async_pc", 64'(debug_wb_pc), 64'd0);
    chk("async_fwd1", 64'(fwd_hit1), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    retire_hold = 1'b0;
    step(4);

    for (int c = 0; c < 400; c++) begin
      if (!(in_valid && !acc_flag)) begin
        set_in($urandom | 32'h4, 1'($urandom), 5'($urandom_range(0, 3)), $urandom,
               1'($urandom), 1'($urandom), $urandom, $urandom);
        in_valid = ($urandom_range(0, 3) != 0);
      end
      retire_hold = ($urandom_range(0, 2) == 0);
      id_raddr1 = 5'($urandom_range(0, 3));
      id_raddr2 = 5'($urandom_range(0, 3));
      step(1);
    end
    in_valid = 1'b0;
    retire_hold = 1'b0;
    step(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
